// File: rtl/mux2_rr_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | mux2_rr_arbiter: round-robin arbiter sharing a 2:1 mux, one-entry out stage  |
// | Optional per-requester grant counters when ARB_GRANT_CNT_EN is defined.      |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
module mux2_rr_arbiter #(
   parameter int size = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            req0_valid_i,
   input  logic [size-1:0] req0_data_i,
   output logic            req0_ready_o,
   input  logic            req1_valid_i,
   input  logic [size-1:0] req1_data_i,
   output logic            req1_ready_o,
   output logic            select_o,
`ifdef ARB_GRANT_CNT_EN
   output logic [15:0]     grant_cnt0_o,
   output logic [15:0]     grant_cnt1_o,
`endif
   output logic            out_valid_o,
   output logic [size-1:0] out_data_o,
   output logic            out_src_o,
   input  logic            out_ready_i
);

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [size-1:0] data_q, data_d;
   logic            src_q, src_d;
   logic            last_grant_q, last_grant_d;

   logic w_can_accept;
   logic w_any_req;
   logic w_grant;
   logic w_grant_valid;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= S_EMPTY;
         data_q       <= '0;
         src_q        <= 1'b0;
         last_grant_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         data_q       <= data_d;
         src_q        <= src_d;
         last_grant_q <= last_grant_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      data_d        = data_q;
      src_d         = src_q;
      last_grant_d  = last_grant_q;
      w_can_accept  = (state_q == S_EMPTY) || out_ready_i;
      w_any_req     = req0_valid_i || req1_valid_i;
      // On contention the side that did not win last time goes next.
      w_grant       = (req0_valid_i && req1_valid_i) ? ~last_grant_q : req1_valid_i;
      w_grant_valid = w_can_accept && w_any_req;

      if (w_grant_valid) begin
         state_d      = S_FULL;
         data_d       = w_grant ? req1_data_i : req0_data_i;
         src_d        = w_grant;
         last_grant_d = w_grant;
      end else if ((state_q == S_FULL) && out_ready_i) begin
         state_d = S_EMPTY;
      end
   end

   assign req0_ready_o = w_grant_valid && !w_grant;
   assign req1_ready_o = w_grant_valid && w_grant;
   assign select_o     = w_grant_valid ? w_grant : last_grant_q;
   assign out_valid_o  = (state_q == S_FULL);
   assign out_data_o   = data_q;
   assign out_src_o    = src_q;

`ifdef ARB_GRANT_CNT_EN
   logic [15:0] cnt0_q, cnt1_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt0_q <= 16'd0;
         cnt1_q <= 16'd0;
      end else begin
         if (req0_ready_o) cnt0_q <= cnt0_q + 16'd1;
         if (req1_ready_o) cnt1_q <= cnt1_q + 16'd1;
      end
   end

   assign grant_cnt0_o = cnt0_q;
   assign grant_cnt1_o = cnt1_q;
`else
   // Counter-free build: no extra state or ports.
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux2_rr_arbiter.sv
`default_nettype none
// Testbench for mux2_rr_arbiter: directed vector table, reset/backpressure
// sequences and randomized traffic checked against a behavioural model.
module tb_mux2_rr_arbiter;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         v0 = 1'b0, v1 = 1'b0, rdy = 1'b0;
   logic [W-1:0] d0 = '0, d1 = '0;
   logic         r0, r1, sel, ov, osrc;
   logic [W-1:0] od;
`ifdef ARB_GRANT_CNT_EN
   logic [15:0]  cnt0, cnt1;
`endif

   mux2_rr_arbiter #(.size(W)) dut (
      .clk_i(clk), .rst_i(rst),
      .req0_valid_i(v0), .req0_data_i(d0), .req0_ready_o(r0),
      .req1_valid_i(v1), .req1_data_i(d1), .req1_ready_o(r1),
      .select_o(sel),
`ifdef ARB_GRANT_CNT_EN
      .grant_cnt0_o(cnt0), .grant_cnt1_o(cnt1),
`endif
      .out_valid_o(ov), .out_data_o(od), .out_src_o(osrc),
      .out_ready_i(rdy)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Behavioural model: a one-word holding slot plus who won last.
   bit           m_full;
   logic [W-1:0] m_data;
   bit           m_src;
   bit           m_last;
   bit [15:0]    m_cnt0, m_cnt1;
   bit           e_r0, e_r1, e_sel;

   task automatic model_reset();
      m_full = 0; m_data = '0; m_src = 0; m_last = 1; m_cnt0 = 0; m_cnt1 = 0;
   endtask

   // Fills e_* for the present cycle and returns whether a word is taken and by whom.
   task automatic model_eval(output bit taken, output bit who);
      bit room;
      room  = !m_full || rdy;
      taken = room && (v0 || v1);
      if (v0 && v1) who = !m_last;
      else          who = v1;
      e_r0  = taken && !who;
      e_r1  = taken && who;
      e_sel = taken ? who : m_last;
   endtask

   task automatic model_commit(input bit taken, input bit who);
      if (taken) begin
         m_data = who ? d1 : d0;
         m_src  = who;
         m_full = 1;
         m_last = who;
         if (who) m_cnt1++; else m_cnt0++;
      end else if (m_full && rdy) begin
         m_full = 0;
      end
   endtask

   // One clock: inputs already driven; compare mid-cycle, then advance model with the edge.
   task automatic cycle(input bit check_model);
      bit taken, who;
      #2;
      model_eval(taken, who);
      if (check_model) begin
         chk("ready0", r0, e_r0);
         chk("ready1", r1, e_r1);
         chk("select", sel, e_sel);
         chk("out_valid", ov, m_full);
         if (m_full) begin
            chk("out_data", od, m_data);
            chk("out_src", osrc, m_src);
         end
`ifdef ARB_GRANT_CNT_EN
         chk("grant_cnt0", cnt0, m_cnt0);
         chk("grant_cnt1", cnt1, m_cnt1);
`endif
      end
      @(posedge clk);
      model_commit(taken, who);
      #1;
   endtask

   task automatic drive(input bit a0, input logic [W-1:0] x0, input bit a1,
                        input logic [W-1:0] x1, input bit rd);
      v0 = a0; d0 = x0; v1 = a1; d1 = x1; rdy = rd;
   endtask

   typedef struct {
      bit           v0, v1, rdy;
      logic [W-1:0] d0, d1;
      bit           r0, r1, sel, ov, src;
      logic [W-1:0] od;
   } vec_t;

   vec_t tbl[12];

   initial begin
      bit hold0, hold1;
      // inputs                               expected this cycle
      tbl[0]  = '{0,1,1, 32'h0,  32'h11, 0,1,1, 0,0, 32'h0};
      tbl[1]  = '{1,1,1, 32'hA0, 32'hB0, 1,0,0, 1,1, 32'h11};
      tbl[2]  = '{1,1,1, 32'hA1, 32'hB1, 0,1,1, 1,0, 32'hA0};
      tbl[3]  = '{1,1,0, 32'hA2, 32'hB2, 0,0,1, 1,1, 32'hB1};
      tbl[4]  = '{1,1,0, 32'hA2, 32'hB2, 0,0,1, 1,1, 32'hB1};
      tbl[5]  = '{1,1,1, 32'hA2, 32'hB2, 1,0,0, 1,1, 32'hB1};
      tbl[6]  = '{0,0,1, 32'h0,  32'h0,  0,0,0, 1,0, 32'hA2};
      tbl[7]  = '{0,0,1, 32'h0,  32'h0,  0,0,0, 0,0, 32'h0};
      tbl[8]  = '{1,0,0, 32'hC0, 32'h0,  1,0,0, 0,0, 32'h0};
      tbl[9]  = '{0,0,0, 32'h0,  32'h0,  0,0,0, 1,0, 32'hC0};
      tbl[10] = '{0,0,1, 32'h0,  32'h0,  0,0,0, 1,0, 32'hC0};
      tbl[11] = '{0,0,1, 32'h0,  32'h0,  0,0,0, 0,0, 32'h0};

      model_reset();
      @(posedge clk); #1;
      chk("reset out_valid", ov, 1'b0);
      chk("reset out_data", od, '0);
      chk("reset out_src", osrc, 1'b0);
      rst = 1'b0;

      // Directed table from reset.
      for (int i = 0; i < 12; i++) begin
         drive(tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1, tbl[i].rdy);
         #1;
         chk($sformatf("tbl%0d ready0", i), r0, tbl[i].r0);
         chk($sformatf("tbl%0d ready1", i), r1, tbl[i].r1);
         chk($sformatf("tbl%0d select", i), sel, tbl[i].sel);
         chk($sformatf("tbl%0d out_valid", i), ov, tbl[i].ov);
         if (tbl[i].ov) begin
            chk($sformatf("tbl%0d out_data", i), od, tbl[i].od);
            chk($sformatf("tbl%0d out_src", i), osrc, tbl[i].src);
         end
         #1;
         cycle(1'b0);
      end

      // Reset while holding a word: clears immediately, req0 wins next contest.
      drive(1, 32'hDEAD_BEEF, 0, '0, 0);
      cycle(1'b1);
      drive(0, '0, 0, '0, 0);
      #1;
      chk("pre-reset out_data", od, 32'hDEAD_BEEF);
      rst = 1'b1;
      #1;
      chk("async reset out_valid", ov, 1'b0);
      chk("async reset out_data", od, '0);
      rst = 1'b0;
      model_reset();
      drive(1, 32'h1, 1, 32'h2, 1);
      #1;
      chk("post-reset first contest ready0", r0, 1'b1);
      #1;
      cycle(1'b1);
      for (int i = 0; i < 4; i++) begin
         drive(1, 32'h100 + i, 1, 32'h200 + i, 1);
         cycle(1'b1);
      end

      // Randomized traffic with valid/data held until accepted.
      hold0 = 0; hold1 = 0;
      for (int i = 0; i < 1500; i++) begin
         if (!hold0) begin v0 = ($urandom_range(0, 9) < 6); d0 = $urandom; end
         if (!hold1) begin v1 = ($urandom_range(0, 9) < 6); d1 = $urandom; end
         rdy = ($urandom_range(0, 9) < 7);
         begin
            bit taken, who;
            model_eval(taken, who);
            hold0 = v0 && !e_r0;
            hold1 = v1 && !e_r1;
         end
         cycle(1'b1);
      end

`ifdef ARB_GRANT_CNT_EN
      drive(0, '0, 0, '0, 1);
      rst = 1'b1; #1; rst = 1'b0;
      model_reset();
      for (int i = 0; i < 65536; i++) begin
         drive(1, i, 0, '0, 1);
         cycle(1'b0);
      end
      chk("cnt0 wrap", cnt0, 16'd0);
      for (int i = 0; i < 5; i++) begin drive(1, i, 0, '0, 1); cycle(1'b0); end
      for (int i = 0; i < 3; i++) begin drive(0, '0, 1, i, 1); cycle(1'b0); end
      chk("cnt0 five", cnt0, 16'd5);
      chk("cnt1 three", cnt1, 16'd3);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
